// File: rtl/seg7_bus_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_bus_display_pkg
//  Description : Shared types and constants for the seven-segment bus display:
//                bus widths, the segment/decimal-point digit type, register
//                offsets inside the 16-byte window and the all-dark pattern.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_bus_display_pkg;

    // Bus widths expressed as MSB index (width = value + 1).
    localparam int BUS_DATA_ = 31;
    localparam int BUS_ADDR_ = 31;

    // One digit: decimal point in the MSB, segments g..a in bits 6..0.
    typedef struct packed {
        logic       p;
        logic [6:0] seg;
    } seg7p_t;

    // Register offsets, selected by bus_addr[3:2].
    localparam logic [1:0] SEG7_OFF_VALUE = 2'd0;
    localparam logic [1:0] SEG7_OFF_DP    = 2'd1;
    localparam logic [1:0] SEG7_OFF_BLANK = 2'd2;
    localparam logic [1:0] SEG7_OFF_BLINK = 2'd3;

    // Active-low pattern with every segment and the point dark.
    localparam seg7p_t SEG7_BLANK = 8'hFF;

endpackage : seg7_bus_display_pkg
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational hex nibble to seven-segment decoder, active-high
//                (1 = segment lit). Glyphs 0-9, A, b, C, d, E, F. The decimal
//                point output is always 0; the caller supplies it.
//  Ports       : i_nibble  [3:0]  value to display
//                o_seg     seg7p_t active-high segments, p = 0
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decoder
    import seg7_bus_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7p_t     o_seg
);

    logic [6:0] w_seg;

    // Bit order is g f e d c b a (bit 0 = segment a).
    always_comb begin
        w_seg = 7'h00;
        case (i_nibble)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            4'hF: w_seg = 7'h71;
            default: w_seg = 7'h00;
        endcase
    end

    assign o_seg = '{p: 1'b0, seg: w_seg};

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/seg7_bus_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_bus_display
//  Description : Memory-mapped slave driving six active-low seven-segment
//                digits. Registers (word offsets): 0 VALUE[23:0], 1 DP[5:0],
//                2 BLANK[5:0], 3 BLINK[5:0]. Optional blink logic is compiled
//                in when the macro SEG7_BLINK_EN is defined; otherwise offset 3
//                reads 0, ignores writes, and digits never blink.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                bus_req/we    request (held until ack), write enable
//                bus_addr      byte address, bus_wdata write data
//                bus_rdata     read data, valid while bus_ack = 1
//                bus_ack       single-cycle completion pulse
//                hex[5:0]      digit 0 = HEX0 (rightmost), active-low
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_bus_display
    import seg7_bus_display_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          BLINK_HZ  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bus_req,
    input  logic                 bus_we,
    input  logic [BUS_ADDR_:0]   bus_addr,
    input  logic [BUS_DATA_:0]   bus_wdata,
    output logic [BUS_DATA_:0]   bus_rdata,
    output logic                 bus_ack,
    output seg7p_t [5:0]         hex
);

    // ------------------------------------------------------------------
    // Register file and bus handshake
    // ------------------------------------------------------------------
    logic [23:0]        r_value;
    logic [5:0]         r_dp;
    logic [5:0]         r_blank;
    logic               r_ack;
    logic [BUS_DATA_:0] r_rdata;
    seg7p_t [5:0]       r_hex;

    logic               w_hit;
    logic               w_accept;
    logic [1:0]         w_off;
    logic [BUS_DATA_:0] w_rd;
    logic [5:0]         w_blink_dark;
    logic [5:0]         w_blink_rd;

    assign w_hit    = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off    = bus_addr[3:2];
    // Blocking on r_ack forces an idle cycle between back-to-back requests.
    assign w_accept = bus_req & w_hit & ~r_ack;

    // Byte-lane bits and unmapped data bits carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, bus_addr[1:0], bus_wdata[31:24]};

    always_comb begin
        w_rd = '0;
        case (w_off)
            SEG7_OFF_VALUE: w_rd = {8'h00, r_value};
            SEG7_OFF_DP:    w_rd = {26'h0, r_dp};
            SEG7_OFF_BLANK: w_rd = {26'h0, r_blank};
            SEG7_OFF_BLINK: w_rd = {26'h0, w_blink_rd};
            default:        w_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_dp    <= '0;
            r_blank <= 6'h3F;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_accept;
            r_rdata <= w_accept ? w_rd : '0;
            if (w_accept && bus_we) begin
                case (w_off)
                    SEG7_OFF_VALUE: r_value <= bus_wdata[23:0];
                    SEG7_OFF_DP:    r_dp    <= bus_wdata[5:0];
                    SEG7_OFF_BLANK: r_blank <= bus_wdata[5:0];
                    default:        ; // BLINK handled with the prescaler
                endcase
            end
        end
    end

    assign bus_ack   = r_ack;
    assign bus_rdata = r_rdata;

    // ------------------------------------------------------------------
    // Blink register and prescaler
    // ------------------------------------------------------------------
`ifdef SEG7_BLINK_EN
    localparam int c_term  = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_pre_w = (c_term > 1) ? $clog2(c_term) : 1;
    localparam logic [c_pre_w-1:0] c_cnt_max = c_pre_w'(c_term - 1);

    logic [5:0]         r_blink;
    logic [c_pre_w-1:0] r_cnt;
    logic               r_phase_on;
    logic               w_blink_wr;

    assign w_blink_wr = w_accept & bus_we & (w_off == SEG7_OFF_BLINK);

    // A BLINK write restarts the cadence and takes priority over a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink    <= '0;
            r_cnt      <= '0;
            r_phase_on <= 1'b1;
        end else if (w_blink_wr) begin
            r_blink    <= bus_wdata[5:0];
            r_cnt      <= '0;
            r_phase_on <= 1'b1;
        end else if (r_cnt == c_cnt_max) begin
            r_cnt      <= '0;
            r_phase_on <= ~r_phase_on;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
        end
    end

    assign w_blink_rd   = r_blink;
    assign w_blink_dark = r_blink & {6{~r_phase_on}};
`else
    localparam int c_unused_blink_cfg = CLK_HZ + BLINK_HZ;

    assign w_blink_rd   = 6'h00;
    assign w_blink_dark = 6'h00;
`endif

    // ------------------------------------------------------------------
    // Digit decode and registered, active-low output
    // ------------------------------------------------------------------
    seg7p_t [5:0] w_dec;
    seg7p_t [5:0] w_hex_next;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            seg7_decoder u_dec (
                .i_nibble (r_value[4*gi +: 4]),
                .o_seg    (w_dec[gi])
            );

            logic [7:0] w_lit;
            assign w_lit = {r_dp[gi], w_dec[gi].seg};

            assign w_hex_next[gi] = (r_blank[gi] || w_blink_dark[gi])
                                    ? SEG7_BLANK : seg7p_t'(~w_lit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex <= {6{SEG7_BLANK}};
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign hex = r_hex;

endmodule : seg7_bus_display
`default_nettype wire

// File: tb/tb_seg7_bus_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_bus_display
//  Description : Self-checking bench for seg7_bus_display. Expected read data
//                is queued when a transaction is issued and compared when the
//                DUT acknowledges; display contents come from a local glyph
//                table. Blink expectations follow SEG7_BLINK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_bus_display;
    import seg7_bus_display_pkg::*;

    localparam logic [31:0] c_base = 32'hFFFF_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ack;
    seg7p_t [5:0] hex;

    seg7_bus_display #(
        .BASE_ADDR (c_base),
        .CLK_HZ    (8),
        .BLINK_HZ  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .hex       (hex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_acks   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Standard glyphs, active-high, bit 0 = segment a.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    function automatic logic [47:0] exp_hex(input logic [23:0] v, input logic [5:0] dp,
                                            input logic [5:0] dark);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) begin
            if (dark[i]) r[8*i +: 8] = 8'hFF;
            else         r[8*i +: 8] = ~{dp[i], glyph(v[4*i +: 4])};
        end
        return r;
    endfunction

    // Scoreboard side: every ack consumes one queued expectation.
    always @(negedge clk) begin
        if (bus_ack) begin
            exp_t e;
            n_acks++;
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) chk("rdata", 64'(bus_rdata), 64'(e.d));
            end
        end
    end

    // Issue one hit transaction; returns one cycle after the ack cycle.
    task automatic bus_op(input logic we, input logic [1:0] off, input logic [31:0] wd,
                          input logic rchk, input logic [31:0] rexp);
        int k;
        exp_t e;
        e.chk = rchk;
        e.d   = rexp;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = c_base | {28'h0, off, 2'b00};
        bus_wdata = wd;
        @(posedge clk);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus_ack) break;
        end
        chk("ack_latency", 64'(k), 64'd1);
        if (k > 20) void'(exp_q.pop_back());
        @(posedge clk); #1;
        bus_req = 1'b0;
        bus_we  = 1'b0;
    endtask

    initial begin
        int acks0;
        logic [5:0] dark;
        logic [31:0] blink_rd;

        rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hex",   64'(hex), 64'({6{8'hFF}}));
        chk("reset_ack",   64'(bus_ack), 64'd0);
        chk("reset_rdata", 64'(bus_rdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        bus_op(1'b0, SEG7_OFF_BLANK, 32'h0, 1'b1, 32'h0000_003F);

        bus_op(1'b1, SEG7_OFF_VALUE, 32'h0012_3456, 1'b0, 32'h0);
        bus_op(1'b1, SEG7_OFF_BLANK, 32'h0, 1'b0, 32'h0);
        chk("hex_value", 64'(hex), 64'(exp_hex(24'h123456, 6'h00, 6'h00)));
        chk("hex0_digit6", 64'(hex[0]), 64'({1'b1, ~glyph(4'h6)}));
        chk("hex5_digit1", 64'(hex[5]), 64'({1'b1, ~glyph(4'h1)}));

        bus_op(1'b1, SEG7_OFF_DP, 32'hFFFF_FF21, 1'b0, 32'h0);
        chk("hex_dp", 64'(hex), 64'(exp_hex(24'h123456, 6'h21, 6'h00)));
        bus_op(1'b0, SEG7_OFF_DP, 32'h0, 1'b1, 32'h0000_0021);

        // Miss: one window above the base, held for 10 cycles.
        acks0 = n_acks;
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = c_base + 32'd16; bus_wdata = 32'h0;
        repeat (10) @(posedge clk);
        #1;
        bus_req = 1'b0; bus_we = 1'b0;
        chk("miss_no_ack", 64'(n_acks - acks0), 64'd0);
        bus_op(1'b0, SEG7_OFF_VALUE, 32'h0, 1'b1, 32'h0012_3456);
        chk("miss_hex_same", 64'(hex), 64'(exp_hex(24'h123456, 6'h21, 6'h00)));

        // Blink digit 0: with CLK_HZ=8, BLINK_HZ=1 the phase flips every 4 cycles.
        bus_op(1'b1, SEG7_OFF_BLINK, 32'h0000_0001, 1'b0, 32'h0);
        for (int j = 0; j < 16; j++) begin
            if (j != 0) begin
                @(posedge clk); #1;
            end
`ifdef SEG7_BLINK_EN
            dark = ((j / 4) % 2 == 1) ? 6'h01 : 6'h00;
`else
            dark = 6'h00;
`endif
            chk($sformatf("blink_j%0d", j), 64'(hex), 64'(exp_hex(24'h123456, 6'h21, dark)));
        end
`ifdef SEG7_BLINK_EN
        blink_rd = 32'h1;
`else
        blink_rd = 32'h0;
`endif
        bus_op(1'b0, SEG7_OFF_BLINK, 32'h0, 1'b1, blink_rd);

        // Reset lands on the edge that would accept a write: it must be aborted.
        acks0 = n_acks;
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = c_base; bus_wdata = 32'h00FF_FFFF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_req = 1'b0; bus_we = 1'b0; rst = 1'b0;
        chk("rst_abort_no_ack", 64'(n_acks - acks0), 64'd0);
        chk("rst_abort_hex", 64'(hex), 64'({6{8'hFF}}));
        bus_op(1'b0, SEG7_OFF_VALUE, 32'h0, 1'b1, 32'h0);
        bus_op(1'b0, SEG7_OFF_BLINK, 32'h0, 1'b1, 32'h0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seg7_bus_display
`default_nettype wire
